alu_risc_pipe: RTL and testbench

Registered, handshaked ALU for the RISC-SPM datapath. It is the parametrised successor to the combinational ALU: width is configurable, and results and a full flag set (zero, carry, negative, overflow) are registered. It adds OR/XOR/shift operations and an iterative multi-cycle multiply. It sits between the controller's operand registers and the register-file write-back, with valid/ready on both sides so the controller can stall on multiply or back-pressure.

---
 rtl/risc_pkg.sv | 44 ++++
 rtl/alu_risc_pipe_if.sv | 46 ++++
 rtl/alu_risc_mul_iter.sv | 92 +++++++++
 rtl/alu_risc_pipe.sv | 165 ++++++++++++++++
 tb/tb_alu_risc_pipe.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the RISC-SPM pipelined ALU:
//   - opcode encodings (NOP .. MUL, including the controller-only RD/WR/BR/BRZ
//     codes that the ALU treats as NOP)
//   - handshake FSM state encoding (IDLE, MUL_BUSY, HOLD)
//   - flag bundle ordering {zero, carry, neg, ovf}
// -----------------------------------------------------------------------------
package risc_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_SHL = 4'd11;
    localparam logic [3:0] OP_SHR = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        HOLD     = 2'd2
    } alu_state_e;

    // Flag bundle, MSB first: zero, carry, neg, ovf.
    typedef struct packed {
        logic zero;
        logic carry;
        logic neg;
        logic ovf;
    } alu_flags_t;

    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_risc_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_risc_pipe_if
// Operand / result bus of the pipelined ALU.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. A producer holding valid high keeps its payload
// stable until the transfer; valid never drops without a transfer, except via
// abort or reset. ready may depend combinationally on the other side's ready.
//
//   master (controller): in_valid, select, data_1, data_2, abort, out_ready
//   slave  (ALU)       : in_ready, out_valid, alu_out, flags, dbg_state
// -----------------------------------------------------------------------------
interface alu_risc_pipe_if #(
    parameter int DATAWIDTH   = 8,
    parameter int opcode_size = 4
);
    import risc_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [opcode_size-1:0] select;
    logic [DATAWIDTH-1:0]   data_1;
    logic [DATAWIDTH-1:0]   data_2;
    logic                   abort;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATAWIDTH-1:0]   alu_out;
    logic                   alu_zero_flag;
    logic                   alu_carry_flag;
    logic                   alu_neg_flag;
    logic                   alu_ovf_flag;
    alu_state_e             dbg_state;

    modport master (
        output in_valid, select, data_1, data_2, abort, out_ready,
        input  in_ready, out_valid, alu_out, alu_zero_flag, alu_carry_flag,
               alu_neg_flag, alu_ovf_flag, dbg_state
    );

    modport slave (
        input  in_valid, select, data_1, data_2, abort, out_ready,
        output in_ready, out_valid, alu_out, alu_zero_flag, alu_carry_flag,
               alu_neg_flag, alu_ovf_flag, dbg_state
    );

endinterface

// File: rtl/alu_risc_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_risc_mul_iter
// Iterative shift-add unsigned multiplier. The operands are captured on start
// and bit 0 of B is folded in immediately, so the remaining DATAWIDTH-1 bits
// take one cycle each; done is high for exactly one cycle, DATAWIDTH-1 cycles
// after the start edge, so the consumer registers the product on the
// DATAWIDTH-th edge after start.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clear_i     synchronous clear, discards any multiply in progress
//   start_i     capture a_i/b_i and begin
//   a_i, b_i    operands (DATAWIDTH)
//   done_o      product_o is final this cycle
//   product_o   full 2*DATAWIDTH-bit product
// -----------------------------------------------------------------------------
module alu_risc_mul_iter #(
    parameter int DATAWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [DATAWIDTH-1:0]     a_i,
    input  logic [DATAWIDTH-1:0]     b_i,
    output logic                     done_o,
    output logic [2*DATAWIDTH-1:0]   product_o
);
    localparam int              CW       = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATAWIDTH);

    logic                     busy_q,   busy_d;
    logic [CW-1:0]            cnt_q,    cnt_d;
    logic [2*DATAWIDTH-1:0]   acc_q,    acc_d;
    logic [2*DATAWIDTH-1:0]   mcand_q,  mcand_d;
    logic [DATAWIDTH-1:0]     mplier_q, mplier_d;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (clear_i) begin
            busy_d   = 1'b0;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
        end else if (start_i) begin
            // Bit 0 of B is consumed at capture time.
            busy_d   = 1'b1;
            cnt_d    = CW'(1);
            acc_d    = b_i[0] ? {{DATAWIDTH{1'b0}}, a_i} : '0;
            mcand_d  = {{DATAWIDTH{1'b0}}, a_i} << 1;
            mplier_d = b_i >> 1;
        end else if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                // Product consumed this cycle; go idle.
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign done_o    = busy_q && (cnt_q == CNT_LAST);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_risc_pipe.sv
// -----------------------------------------------------------------------------
// alu_risc_pipe
// Registered, handshaked ALU for the RISC-SPM datapath. Single-cycle ops
// (ADD SUB AND NOT OR XOR SHL SHR, NOP-like codes) are computed combinationally
// from the bus and registered on accept; MUL runs on alu_risc_mul_iter.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    alu_risc_pipe_if.slave: in_valid/in_ready, select, data_1, data_2,
//          abort, out_valid/out_ready, alu_out, four flags, dbg_state
//
// State meaning: IDLE = free, possibly presenting a fresh result; MUL_BUSY =
// multiply in progress; HOLD = a result is being held under back-pressure.
// in_ready is (not MUL_BUSY) && (no result pending || it drains this cycle),
// which gives full throughput and drain+accept in the same cycle.
// -----------------------------------------------------------------------------
module alu_risc_pipe #(
    parameter int DATAWIDTH   = 8,
    parameter int opcode_size = 4,
    parameter int SHW         = $clog2(DATAWIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_risc_pipe_if.slave   bus
);
    import risc_pkg::*;

    localparam int MSB = DATAWIDTH - 1;

    alu_state_e               state_q;
    logic                     out_valid_q;
    logic [DATAWIDTH-1:0]     alu_out_q;
    alu_flags_t               flags_q;

    logic [3:0]               op;
    logic [SHW-1:0]           shamt;
    logic [DATAWIDTH:0]       sum_w, diff_w, shl_w;
    logic [DATAWIDTH-1:0]     res_d;
    alu_flags_t               flags_d;
    logic                     in_ready_w, accept, mul_start, mul_done;
    logic [2*DATAWIDTH-1:0]   mul_product;
    logic [DATAWIDTH-1:0]     mul_res_d;
    alu_flags_t               mul_flags_d;

    assign op     = 4'(bus.select);
    assign shamt  = bus.data_2[SHW-1:0];
    assign sum_w  = {1'b0, bus.data_1} + {1'b0, bus.data_2};
    assign diff_w = {1'b0, bus.data_1} - {1'b0, bus.data_2};
    // Bit DATAWIDTH of the widened shift is the last bit shifted out
    // (zero when the amount is zero).
    assign shl_w  = {1'b0, bus.data_1} << shamt;

    // Single-cycle result and flags.
    always_comb begin
        res_d         = '0;
        flags_d       = '0;
        case (op)
            OP_ADD: begin
                res_d         = sum_w[MSB:0];
                flags_d.carry = sum_w[DATAWIDTH];
                flags_d.ovf   = (bus.data_1[MSB] == bus.data_2[MSB]) &&
                                (res_d[MSB] != bus.data_1[MSB]);
            end
            OP_SUB: begin
                res_d         = diff_w[MSB:0];
                flags_d.carry = diff_w[DATAWIDTH];
                flags_d.ovf   = (bus.data_1[MSB] != bus.data_2[MSB]) &&
                                (res_d[MSB] != bus.data_1[MSB]);
            end
            OP_AND: res_d = bus.data_1 & bus.data_2;
            OP_NOT: res_d = ~bus.data_1;
            OP_OR:  res_d = bus.data_1 | bus.data_2;
            OP_XOR: res_d = bus.data_1 ^ bus.data_2;
            OP_SHL: begin
                res_d         = shl_w[MSB:0];
                flags_d.carry = shl_w[DATAWIDTH];
            end
            OP_SHR: res_d = bus.data_1 >> shamt;
            OP_NOP, OP_RD, OP_WR, OP_BR, OP_BRZ: res_d = '0;
            default: res_d = '0;
        endcase
        flags_d.zero = (res_d == '0);
        flags_d.neg  = res_d[MSB];
    end

    // Multiply result: low half, carry when the high half is nonzero.
    always_comb begin
        mul_res_d         = mul_product[MSB:0];
        mul_flags_d       = '0;
        mul_flags_d.zero  = (mul_res_d == '0);
        mul_flags_d.carry = |mul_product[2*DATAWIDTH-1:DATAWIDTH];
        mul_flags_d.neg   = mul_res_d[MSB];
    end

    assign in_ready_w = (state_q != MUL_BUSY) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;
    assign mul_start  = accept && is_mul(op) && !bus.abort;

    alu_risc_mul_iter #(
        .DATAWIDTH (DATAWIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (bus.abort),
        .start_i   (mul_start),
        .a_i       (bus.data_1),
        .b_i       (bus.data_2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Handshake FSM with registered outputs. abort outranks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
        end else if (bus.abort) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MUL_BUSY: begin
                    if (mul_done) begin
                        alu_out_q   <= mul_res_d;
                        flags_q     <= mul_flags_d;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    if (accept) begin
                        // Any pending result drains on this same edge.
                        if (is_mul(op)) begin
                            out_valid_q <= 1'b0;
                            state_q     <= MUL_BUSY;
                        end else begin
                            alu_out_q   <= res_d;
                            flags_q     <= flags_d;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (out_valid_q) begin
                        state_q     <= HOLD;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_w;
    assign bus.out_valid      = out_valid_q;
    assign bus.alu_out        = alu_out_q;
    assign bus.alu_zero_flag  = flags_q.zero;
    assign bus.alu_carry_flag = flags_q.carry;
    assign bus.alu_neg_flag   = flags_q.neg;
    assign bus.alu_ovf_flag   = flags_q.ovf;
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_alu_risc_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_risc_pipe
// Directed bench for alu_risc_pipe (DATAWIDTH=8). A behavioural model computes
// every accepted operation's result from plain integer arithmetic; a negedge
// monitor compares each retired result against it and checks hold stability.
// Directed sequences add literal expectations, latency and handshake checks.
// -----------------------------------------------------------------------------
module tb_alu_risc_pipe;
    import risc_pkg::*;

    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [11:0] exp_q[$];
    logic [11:0] dut_w;
    logic [11:0] prev_w;
    logic        prev_hold;

    alu_risc_pipe_if #(.DATAWIDTH(DW), .opcode_size(4)) bus ();

    alu_risc_pipe #(.DATAWIDTH(DW), .opcode_size(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign dut_w = {bus.alu_out, bus.alu_zero_flag, bus.alu_carry_flag,
                    bus.alu_neg_flag, bus.alu_ovf_flag};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    // ---------------- model ----------------
    // Returns {result[7:0], zero, carry, neg, ovf}.
    function automatic logic [11:0] model(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        int ia, ib, sa, sb, full, sh;
        logic [7:0] r;
        logic c, v;
        ia = a; ib = b; sa = $signed(a); sb = $signed(b);
        sh = ib % 8;
        r = 8'h00; c = 1'b0; v = 1'b0; full = 0;
        case (op)
            4'd1: begin
                full = ia + ib; r = full[7:0]; c = (full > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            4'd2: begin
                full = ia - ib; r = full[7:0]; c = (ia < ib);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            4'd3:  r = a & b;
            4'd4:  r = ~a;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: begin
                full = ia << sh; r = full[7:0];
                c = (sh != 0) && (((ia >> (8 - sh)) & 1) == 1);
            end
            4'd12: begin full = ia >> sh; r = full[7:0]; end
            4'd13: begin full = ia * ib; r = full[7:0]; c = (full > 255); end
            default: r = 8'h00;
        endcase
        return {r, (r == 8'h00), c, r[7], v};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string name, input logic [7:0] res,
                              input logic z, input logic c, input logic n, input logic v);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check(name, 32'(dut_w), 32'({res, z, c, n, v}));
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_stable", 32'(dut_w), 32'(prev_w));
            end
            if (bus.out_valid && bus.out_ready && !bus.abort) begin
                check("sb_depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) check("sb_result", 32'(dut_w), 32'(exp_q.pop_front()));
            end
            if (bus.abort) exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.select, bus.data_1, bus.data_2));
            prev_hold = bus.out_valid && !bus.out_ready && !bus.abort;
            prev_w    = dut_w;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.select = op; bus.data_1 = a; bus.data_2 = b; bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.abort) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Issues a MUL and checks the DATAWIDTH-cycle latency and in_ready=0.
    task automatic mul_check(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] res, input logic z, input logic c, input logic n);
        issue(OP_MUL, a, b);
        for (int k = 0; k < DW; k++) begin
            @(negedge clk);
            check({name, "_busy_valid"}, 32'(bus.out_valid), 32'd0);
            check({name, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        expect_out(name, res, z, c, n, 1'b0);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, res;
        logic       z, c, n, v;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 0, 1, 0, 0};
        vecs[1]  = '{OP_SHL, 8'h81, 8'h00, 8'h81, 0, 0, 1, 0};
        vecs[2]  = '{OP_BR,  8'h12, 8'h34, 8'h00, 1, 0, 0, 0};
        vecs[3]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0};
        vecs[4]  = '{OP_NOT, 8'h0F, 8'h55, 8'hF0, 0, 0, 1, 0};
        vecs[5]  = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 0, 0, 1, 0};
        vecs[6]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1, 0, 0, 0};
        vecs[7]  = '{OP_SHR, 8'h80, 8'h07, 8'h01, 0, 0, 0, 0};
        vecs[8]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1};
        vecs[9]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0};
        vecs[10] = '{OP_SHL, 8'h01, 8'h0F, 8'h80, 0, 0, 1, 0};
        vecs[11] = '{OP_SHL, 8'hC0, 8'h0A, 8'h00, 1, 1, 0, 0};
        vecs[12] = '{4'd15,  8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0};
        vecs[13] = '{OP_NOP, 8'h12, 8'h34, 8'h00, 1, 0, 0, 0};
        vecs[14] = '{OP_SUB, 8'h80, 8'h7F, 8'h01, 0, 0, 0, 1};
        vecs[15] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1, 1, 0, 1};
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_vec = 0; n_err = 0;
        prev_hold = 1'b0; prev_w = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.select = '0; bus.data_1 = '0; bus.data_2 = '0;
        bus.abort = 1'b0; bus.out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs", 32'(dut_w), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // ADD / SUB, result visible the cycle after accept.
        issue(OP_ADD, 8'hFF, 8'h01);
        @(negedge clk); expect_out("add_ff_01", 8'h00, 1, 1, 0, 0);
        issue(OP_SUB, 8'h80, 8'h01);
        @(negedge clk); expect_out("sub_80_01", 8'h7F, 0, 0, 0, 1);
        issue(OP_SUB, 8'h01, 8'h02);
        @(negedge clk); expect_out("sub_01_02", 8'hFF, 0, 1, 1, 0);

        // Multiply.
        mul_check("mul_15x17", 8'd15, 8'd17, 8'hFF, 0, 0, 1);
        mul_check("mul_16x16", 8'd16, 8'd16, 8'h00, 1, 1, 0);

        // Back-pressure, then drain and accept on the same edge.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        issue(OP_ADD, 8'h03, 8'h04);
        bus.select = OP_ADD; bus.data_1 = 8'h10; bus.data_2 = 8'h20; bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            expect_out("bp_held", 8'h07, 0, 0, 0, 0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_ready", 32'(bus.in_ready), 32'd1);
        expect_out("bp_drain", 8'h07, 0, 0, 0, 0);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk); expect_out("bp_second", 8'h30, 0, 0, 0, 0);

        // Back-to-back single-cycle vectors at full throughput.
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            bus.select = vecs[i].op; bus.data_1 = vecs[i].a; bus.data_2 = vecs[i].b;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("tput_in_ready", 32'(bus.in_ready), 32'd1);
            if (i > 0) expect_out($sformatf("vec%0d", i - 1), vecs[i-1].res,
                                  vecs[i-1].z, vecs[i-1].c, vecs[i-1].n, vecs[i-1].v);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        expect_out("vec15", vecs[15].res, vecs[15].z, vecs[15].c, vecs[15].n, vecs[15].v);

        // Abort mid-multiply.
        issue(OP_MUL, 8'h05, 8'h06);
        repeat (3) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (12) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus.out_valid), 32'd0);
        end

        // abort outranks accept.
        @(posedge clk); #1;
        bus.select = OP_ADD; bus.data_1 = 8'h01; bus.data_2 = 8'h01;
        bus.in_valid = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        check("abort_prio_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-multiply, then a fresh ADD.
        issue(OP_MUL, 8'h07, 8'h09);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mul_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mul_outputs", 32'(dut_w), 32'd0);
        check("rst_mul_state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_valid", 32'(bus.out_valid), 32'd0);
        issue(OP_ADD, 8'h02, 8'h03);
        @(negedge clk); expect_out("add_after_rst", 8'h05, 0, 0, 0, 0);

        // Everything accepted must have retired.
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
